cpu_prefetch_unit: RTL and testbench

//  Parametrised fetch stage with an instruction prefetch queue. It sits between the PC/branch logic and decode.
//  It keeps up to MAX_OUTSTANDING icache requests in flight and buffers in-order responses with their PCs
//  in a QUEUE_DEPTH FIFO. It presents them to decode through a valid/ready handshake.
//  A redirect (branch/exception) flushes the queue and squashes in-flight responses.

---
 rtl/cpu_prefetch_unit.sv | 117 +++++++++++
 tb/tb_cpu_prefetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_prefetch_unit.sv
// Instruction prefetch stage. Issues sequential icache requests from fetch_pc,
// keeps up to MAX_OUTSTANDING in flight, buffers in-order responses together
// with their PCs in a small FIFO and hands them to decode over valid/ready.
// A redirect flushes the FIFO and marks every unanswered request as stale, so
// its response is discarded when it eventually arrives.
module cpu_prefetch_unit #(
  parameter int                ADDR_W          = 32,
  parameter int                INSTR_W         = 32,
  parameter logic [ADDR_W-1:0] BOOT_ADDR       = 'h0000_1000,
  parameter int                PC_STEP         = 4,
  parameter int                QUEUE_DEPTH     = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               icache_req_valid,
  input  logic               icache_req_ready,
  output logic [ADDR_W-1:0]  icache_req_addr,
  input  logic               icache_rsp_valid,
  input  logic [INSTR_W-1:0] icache_rsp_word,
  output logic               decode_valid,
  input  logic               decode_ready,
  output logic [INSTR_W-1:0] decode_instr,
  output logic [ADDR_W-1:0]  decode_pc,
  output logic [ADDR_W-1:0]  decode_next_pc
);

  localparam int IF_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int SUM_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             mem [QUEUE_DEPTH];
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  fill_pc;
  logic [IF_W-1:0]    inflight;
  logic [IF_W-1:0]    drop;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [SUM_W-1:0]   reserved;
  logic               req_fire;
  logic               push;
  logic               pop;

  // Slots already owned: queued entries plus live (non-stale) requests.
  assign reserved = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(drop);

  // NOTE: reset gates the handshake outputs combinationally so they drop the
  // instant reset asserts, not at the next clock edge.
  assign icache_req_valid = reset && !redirect_valid
                         && (inflight < IF_W'(MAX_OUTSTANDING))
                         && (reserved < SUM_W'(QUEUE_DEPTH));
  assign icache_req_addr  = fetch_pc;
  assign req_fire         = icache_req_valid && icache_req_ready;

  assign push             = icache_rsp_valid && !redirect_valid && (drop == '0);
  assign decode_valid     = reset && (count != '0) && !redirect_valid;
  assign pop              = decode_valid && decode_ready;

  assign decode_pc        = mem[rd_ptr].pc;
  assign decode_instr     = mem[rd_ptr].instr;
  assign decode_next_pc   = mem[rd_ptr].pc + STEP;

  // Control state: PCs, in-flight/stale counters and FIFO pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= BOOT_ADDR;
      fill_pc  <= BOOT_ADDR;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      // NOTE: non-blocking assignments so every register here sees the
      // pre-edge value of inflight, which both updates below depend on.
      fetch_pc <= redirect_pc;
      fill_pc  <= redirect_pc;
      inflight <= inflight - IF_W'(icache_rsp_valid);
      drop     <= inflight - IF_W'(icache_rsp_valid);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + STEP;
      inflight <= inflight + IF_W'(req_fire) - IF_W'(icache_rsp_valid);
      if (icache_rsp_valid && (drop != '0)) drop <= drop - IF_W'(1);
      if (push) begin
        fill_pc <= fill_pc + STEP;
        wr_ptr  <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; count gates every read, so its
  // contents never matter until written.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{pc: fill_pc, instr: icache_rsp_word};
  end

  // Space reservation must make a push into a full queue impossible.
  assert property (@(posedge clock) disable iff (!reset)
                   !(push && (count == CNT_W'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_cpu_prefetch_unit.sv
// Bench for cpu_prefetch_unit: an icache model with random in-order latency,
// a queue-based reference of the fetch stage, per-cycle output comparison and
// a set of directed scenarios with literal expectations.
module tb_cpu_prefetch_unit;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        icache_req_valid;
  logic        icache_req_ready = 1'b0;
  logic [31:0] icache_req_addr;
  logic        icache_rsp_valid = 1'b0;
  logic [31:0] icache_rsp_word = '0;
  logic        decode_valid;
  logic        decode_ready = 1'b0;
  logic [31:0] decode_instr;
  logic [31:0] decode_pc;
  logic [31:0] decode_next_pc;

  always #5 clock = ~clock;

  cpu_prefetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .icache_req_valid (icache_req_valid),
    .icache_req_ready (icache_req_ready),
    .icache_req_addr  (icache_req_addr),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_word  (icache_rsp_word),
    .decode_valid     (decode_valid),
    .decode_ready     (decode_ready),
    .decode_instr     (decode_instr),
    .decode_pc        (decode_pc),
    .decode_next_pc   (decode_next_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    int          due;
    bit          stale;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  req_t        out_q[$];   // requests accepted by the icache, oldest first
  ent_t        m_q[$];     // instructions waiting for decode
  logic [31:0] m_fetch;
  logic [31:0] pops[$];
  int          pop_cyc[$];
  int          cyc;
  int          last_due;
  int          lat_min;
  int          lat_max;
  int          max_out;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    out_q.delete();
    m_q.delete();
    m_fetch  = 32'h0000_1000;
    last_due = cyc;
  endtask

  function automatic bit rsp_due();
    return (out_q.size() != 0) && (out_q[0].due == cyc);
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model at the
  // falling edge, then advance the model to the state after the rising edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rq_rdy, input bit dc_rdy);
    bit   rsp;
    bit   exp_req;
    bit   exp_dec;
    int   live;
    int   lat;
    int   due;
    req_t r;
    req_t n;
    ent_t e;
    ent_t h;
    rsp = rsp_due();
    redirect_valid   = redir;
    redirect_pc      = rpc;
    icache_req_ready = rq_rdy;
    decode_ready     = dc_rdy;
    icache_rsp_valid = rsp;
    icache_rsp_word  = rsp ? word_of(out_q[0].pc) : 32'h0;
    live = 0;
    foreach (out_q[i]) if (!out_q[i].stale) live++;
    exp_req = !redir && (out_q.size() < MAXO) && ((m_q.size() + live) < DEPTH);
    exp_dec = (m_q.size() != 0) && !redir;

    @(negedge clock);
    check("req_valid", 32'(icache_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", icache_req_addr, m_fetch);
    check("decode_valid", 32'(decode_valid), 32'(exp_dec));
    if (exp_dec) begin
      check("decode_pc", decode_pc, m_q[0].pc);
      check("decode_instr", decode_instr, m_q[0].word);
      check("decode_next_pc", decode_next_pc, m_q[0].pc + 32'd4);
    end

    if (rsp) r = out_q.pop_front();
    if (redir) begin
      m_q.delete();
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      m_fetch = rpc;
    end else begin
      if (exp_dec && dc_rdy) begin
        h = m_q.pop_front();
        pops.push_back(h.pc);
        pop_cyc.push_back(cyc);
      end
      if (rsp && !r.stale) begin
        e.pc   = r.pc;
        e.word = word_of(r.pc);
        m_q.push_back(e);
      end
      if (exp_req && rq_rdy) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        n.pc    = m_fetch;
        n.due   = due;
        n.stale = 1'b0;
        out_q.push_back(n);
        m_fetch = m_fetch + 32'd4;
      end
    end
    if (out_q.size() > max_out) max_out = out_q.size();

    @(posedge clock);
    #1;
    cyc++;
    redirect_valid   = 1'b0;
    icache_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    icache_req_ready = 1'b0;
    icache_rsp_valid = 1'b0;
    icache_rsp_word  = '0;
    decode_ready     = 1'b0;
    model_reset();
    @(negedge clock);
    check("reset_req_valid", 32'(icache_req_valid), 32'h0);
    check("reset_decode_valid", 32'(decode_valid), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    int  k;
    bit  rd;
    bit  rr;
    bit  dr;
    logic [31:0] rp;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    max_out = 0;
    lat_min = 1;
    lat_max = 1;

    // T1: reset release, 1-cycle icache, decode always ready.
    do_reset();
    #1;
    check("t1_first_addr", icache_req_addr, 32'h0000_1000);
    pops.delete();
    pop_cyc.delete();
    t0 = cyc;
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    check("t1_pop0", pops[0], 32'h0000_1000);
    check("t1_pop1", pops[1], 32'h0000_1004);
    check("t1_pop2", pops[2], 32'h0000_1008);
    check("t1_latency", 32'(pop_cyc[0] - t0), 32'd2);
    check("t1_back_to_back_a", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    check("t1_back_to_back_b", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);

    // T2: decode stalled, the queue fills to its depth and fetch stops.
    do_reset();
    repeat (20) step(1'b0, '0, 1'b1, 1'b0);
    check("t2_decode_valid", 32'(decode_valid), 32'h1);
    check("t2_head_pc", decode_pc, 32'h0000_1000);
    check("t2_req_stopped", 32'(icache_req_valid), 32'h0);
    pops.delete();
    repeat (8) step(1'b0, '0, 1'b0, 1'b1);
    check("t2_pop_count", 32'(pops.size()), 32'd4);
    check("t2_pop0", pops[0], 32'h0000_1000);
    check("t2_pop1", pops[1], 32'h0000_1004);
    check("t2_pop2", pops[2], 32'h0000_1008);
    check("t2_pop3", pops[3], 32'h0000_100C);

    // T3: long icache latency, in-flight limit.
    do_reset();
    lat_min = 5;
    lat_max = 5;
    max_out = 0;
    repeat (40) step(1'b0, '0, 1'b1, 1'b1);
    check("t3_max_inflight", 32'(max_out), 32'd2);

    // T4: redirect with requests in flight and entries queued.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    k = 0;
    while (!((m_q.size() >= 2) && (out_q.size() >= 1)) && (k < 50)) begin
      step(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    check("t4_setup", 32'((m_q.size() >= 2) && (out_q.size() >= 1)), 32'h1);
    step(1'b1, 32'h0000_2000, 1'b1, 1'b0);
    check("t4_flushed", 32'(decode_valid), 32'h0);
    pops.delete();
    repeat (20) step(1'b0, '0, 1'b1, 1'b1);
    check("t4_first_pc", pops[0], 32'h0000_2000);
    check("t4_second_pc", pops[1], 32'h0000_2004);

    // T5: redirect in the same cycle as a response, decode ready.
    lat_min = 2;
    lat_max = 2;
    k = 0;
    while (!(rsp_due() && (m_q.size() != 0)) && (k < 50)) begin
      step(1'b0, '0, 1'b1, 1'b1);
      k++;
    end
    check("t5_setup", 32'(rsp_due() && (m_q.size() != 0)), 32'h1);
    pops.delete();
    step(1'b1, 32'h0000_3000, 1'b1, 1'b1);
    check("t5_no_pop", 32'(pops.size()), 32'd0);
    repeat (20) step(1'b0, '0, 1'b1, 1'b1);
    check("t5_first_pc", pops[0], 32'h0000_3000);
    check("t5_second_pc", pops[1], 32'h0000_3004);

    // T6: reset mid-stream with two requests in flight, then PC wrap.
    lat_min = 5;
    lat_max = 5;
    k = 0;
    while ((out_q.size() != 2) && (k < 50)) begin
      step(1'b0, '0, 1'b1, 1'b1);
      k++;
    end
    check("t6_setup", 32'(out_q.size()), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("t6_req_valid_low", 32'(icache_req_valid), 32'h0);
    check("t6_decode_valid_low", 32'(decode_valid), 32'h0);
    do_reset();
    pops.delete();
    repeat (15) step(1'b0, '0, 1'b1, 1'b1);
    check("t6_restart_pc", pops[0], 32'h0000_1000);
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    pops.delete();
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    check("t6_wrap_pc0", pops[0], 32'hFFFF_FFFC);
    check("t6_wrap_pc1", pops[1], 32'h0000_0000);

    // Random traffic: latencies, back-pressure and redirects.
    lat_min = 1;
    lat_max = 5;
    repeat (500) begin
      rd = ($urandom_range(15, 0) == 0);
      rr = ($urandom_range(3, 0) != 0);
      dr = ($urandom_range(3, 0) != 0);
      rp = $urandom & 32'hFFFF_FFFC;
      step(rd, rp, rr, dr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
